// File: rtl/neurotransmitter_level_integrator.sv
// Integrates regulator inc/dec/fast requests into a saturating concentration
// value with idle drift toward baseline, and publishes a 2-bit level with
// hysteresis plus a one-cycle change pulse.
module neurotransmitter_level_integrator #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned STEP         = 1,
  parameter int unsigned FAST_STEP    = 4,
  parameter int unsigned BASELINE     = 64,
  parameter int unsigned DECAY_PERIOD = 8,
  parameter int unsigned HYST         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             inc,
  input  logic             dec,
  input  logic             fast,
  output logic [WIDTH-1:0] value,
  output logic [1:0]       level,
  output logic             level_changed
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = $clog2(DECAY_PERIOD + 1);
  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned Q  = 1 << (WIDTH - 2);

  // Level thresholds, compared at WIDTH+1 bits so B3+HYST cannot overflow
  localparam logic [XW-1:0] UP1 = XW'(Q + HYST);
  localparam logic [XW-1:0] UP2 = XW'(2 * Q + HYST);
  localparam logic [XW-1:0] UP3 = XW'(3 * Q + HYST);
  localparam logic [XW-1:0] DN1 = XW'(Q - HYST);
  localparam logic [XW-1:0] DN2 = XW'(2 * Q - HYST);
  localparam logic [XW-1:0] DN3 = XW'(3 * Q - HYST);

  localparam logic [WIDTH-1:0] BASE_V = WIDTH'(BASELINE);

  typedef enum logic [1:0] {L0 = 2'd0, L1 = 2'd1, L2 = 2'd2, L3 = 2'd3} level_t;
  localparam level_t RST_LVL = level_t'(2'(BASELINE >> (WIDTH - 2)));

  logic [PW-1:0]    pcnt;
  logic [IW-1:0]    idle_q;
  level_t           lvl_q;
  logic             strobe_c;
  logic [XW-1:0]    vx_c;
  logic [XW-1:0]    step_c;
  logic [XW-1:0]    sum_c;
  logic [WIDTH-1:0] value_nxt_c;
  logic [IW-1:0]    idle_nxt_c;

  assign strobe_c = ena && (pcnt == PW'(PRESCALE - 1));
  assign vx_c     = {1'b0, value};
  assign step_c   = fast ? XW'(FAST_STEP) : XW'(STEP);
  assign sum_c    = vx_c + step_c;
  assign level    = lvl_q;

  // Update-rate prescaler; holds its count while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (ena) begin
      pcnt <= strobe_c ? '0 : pcnt + PW'(1);
    end
  end

  // Next concentration and idle count for the current strobe
  always_comb begin
    value_nxt_c = value;
    idle_nxt_c  = idle_q;
    if (strobe_c) begin
      if (inc || dec) begin
        idle_nxt_c = '0;
      end
      if (inc && !dec) begin
        value_nxt_c = sum_c[WIDTH] ? '1 : sum_c[WIDTH-1:0];
      end else if (dec && !inc) begin
        value_nxt_c = (vx_c < step_c) ? '0 : WIDTH'(vx_c - step_c);
      end else if (!inc && !dec) begin
        if (idle_q == IW'(DECAY_PERIOD - 1)) begin
          idle_nxt_c = '0;
          if (value > BASE_V) begin
            value_nxt_c = value - WIDTH'(1);
          end else if (value < BASE_V) begin
            value_nxt_c = value + WIDTH'(1);
          end
        end else begin
          idle_nxt_c = idle_q + IW'(1);
        end
      end
    end
  end

  // Concentration and idle-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value  <= BASE_V;
      idle_q <= '0;
    end else begin
      value  <= value_nxt_c;
      idle_q <= idle_nxt_c;
    end
  end

  // Level FSM with hysteresis: at most one step per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q         <= RST_LVL;
      level_changed <= 1'b0;
    end else begin
      level_changed <= 1'b0;
      if (ena) begin
        case (lvl_q)
          L0: begin
            if (vx_c >= UP1) begin
              lvl_q <= L1; level_changed <= 1'b1;
            end
          end
          L1: begin
            if (vx_c >= UP2) begin
              lvl_q <= L2; level_changed <= 1'b1;
            end else if (vx_c < DN1) begin
              lvl_q <= L0; level_changed <= 1'b1;
            end
          end
          L2: begin
            if (vx_c >= UP3) begin
              lvl_q <= L3; level_changed <= 1'b1;
            end else if (vx_c < DN2) begin
              lvl_q <= L1; level_changed <= 1'b1;
            end
          end
          default: begin
            if (vx_c < DN3) begin
              lvl_q <= L2; level_changed <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/neurotransmitter_level_integrator.md
Name: neurotransmitter_level_integrator

Overview:
- Receiving end of a regulator's inc/dec/fast request interface. Integrates those requests into a saturating internal concentration value for one neurotransmitter (e.g. NE).
- Publishes the 2-bit quantized level that feeds the neurotransmitter_level bus slice consumed by all regulators.
- One instance per neurotransmitter.
- Provides the update-rate prescaler, slow drift back to baseline when idle, and hysteresis on the quantized level, so levels do not chatter.

Parameters:
- WIDTH, 8, bit width of the internal concentration value (>=4).
- PRESCALE, 4, clk cycles per update strobe (>=1).
- STEP, 1, normal increment/decrement per strobe.
- FAST_STEP, 4, increment/decrement per strobe when fast=1.
- BASELINE, 64, reset value and idle drift target.
- DECAY_PERIOD, 8, consecutive idle strobes before one drift step.
- HYST, 4, hysteresis margin around level boundaries.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  global enable; low freezes all state.
- inc  input  1  increase request from regulator.
- dec  input  1  decrease request from regulator.
- fast  input  1  use FAST_STEP instead of STEP.
- value  output  WIDTH  current concentration (registered).
- level  output  2  quantized level with hysteresis (registered).
- level_changed  output  1  one-cycle pulse when level changes.

Behaviour:
- Reset, asynchronous on rst_n low, any time including mid-update:
  - value=BASELINE; level=BASELINE>>(WIDTH-2); level_changed=0.
  - Prescaler=0; idle counter=0.
- Prescaler:
  - Counts 0..PRESCALE-1 while ena=1.
  - Strobe asserts in the cycle where count==PRESCALE-1; count then wraps to 0.
  - First strobe occurs PRESCALE cycles after reset release.
- inc/dec/fast are sampled only on strobe cycles; values between strobes are ignored.
- On strobe, with d = fast ? FAST_STEP : STEP:
  - inc&!dec: value = min(value+d, 2^WIDTH-1). Compute at WIDTH+1 bits, then saturate.
  - dec&!inc: value = max(value-d, 0). No underflow wrap.
  - inc&dec: value held; counts as activity.
  - !inc&!dec (fast alone is ignored): counts as idle.
- Idle counter:
  - Cleared on any strobe with inc or dec.
  - Otherwise increments on each idle strobe.
  - When it reaches DECAY_PERIOD: value moves 1 toward BASELINE (no change if equal) and the idle counter clears, in the same strobe.
- value updates at the clk edge ending the strobe cycle, i.e. latency 1 from sampled request.
- Level FSM: states L0..L3. Boundaries are B1=2^(WIDTH-2), B2=2^(WIDTH-1), B3=3*2^(WIDTH-2).
  - Evaluated every cycle with ena=1, against registered value.
  - From Lk (k<3): go to Lk+1 if value >= B(k+1)+HYST.
  - From Lk (k>0): go to Lk-1 if value < B(k)-HYST.
  - At most one step per cycle, so large jumps settle over successive cycles.
  - Up and down conditions are mutually exclusive by construction.
- level_changed=1 for exactly the cycle after level register changes; otherwise 0. Consecutive steps give consecutive pulses.
- ena=0: prescaler, idle counter, value, level all hold; level_changed forced 0. Resume continues from the held prescaler count.
- Saturation at 0 or max is not idle activity: idle counter still clears because a request was present.

Test Plan (defaults, ena=1 unless stated):
- Reset: assert rst_n=0 mid-count with value=100 -> value=64, level=1, level_changed=0 asynchronously; first strobe 4 cycles after release.
- Normal inc: inc=1, fast=0 for 8 strobes (32 cycles) -> value=72, level stays 1, no level_changed.
- Hysteresis up/down:
  - From 64, inc=1, fast=1 -> value 132 after 17 strobes; level 1->2 one cycle later with a single level_changed pulse.
  - Then dec=1, fast=0 -> level stays 2 down to value 124; drops to 1 one cycle after value=123.
- Saturation: from value=254, inc+fast -> 255 and held on further strobes; from value=2, dec+fast -> 0 and held.
- Decay: value=72, inc=dec=0 -> 71 after 8 strobes, 70 after 16.
  - Inserting one inc&dec strobe at strobe 5 delays the drift to strobe 13, with value unchanged by that strobe.
- Freeze: ena=0 for 100 cycles with inc=1, fast=1 -> value, level, prescaler unchanged, level_changed=0; after ena=1, next strobe arrives after the remaining prescaler count.
